dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
- Sequencer and arbiter in front of the word-wide, 16-entry data RAM of the RV32I core.
- Shares the RAM between two requesters: port A (core load/store) and port B (debug/loader).
- Converts RV32I byte, halfword and word loads and stores (funct3-encoded) into word-only RAM cycles.
- The RAM has no byte enables, so sub-word stores use a read-modify-write sequence.

Parameters:
- ADDR_W, 4, word-index width; RAM depth is 2^ADDR_W words. Byte-address bits [ADDR_W+1:2] select the word; upper bits are ignored, so the address wraps.

Ports:
- iClk  in  1  system clock, rising edge
- iRst_n  in  1  asynchronous active-low reset
- iA_Req / iB_Req  in  1  access request; held high until the matching Gnt
- iA_We / iB_We  in  1  1 = store, 0 = load
- iA_Funct3 / iB_Funct3  in  3  RV32I load/store funct3
- iA_Addr / iB_Addr  in  32  byte address
- iA_WrData / iB_WrData  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0])
- oA_Gnt / oB_Gnt  out  1  one-cycle pulse: request latched
- oA_Done / oB_Done  out  1  one-cycle pulse: access complete
- oA_RdData / oB_RdData  out  32  extended load result; valid while Done is high, held afterwards
- oA_Err / oB_Err  out  1  pulses together with Done when the access was rejected
- oBusy  out  1  FSM not in IDLE
- oRam_WrEn  out  1  RAM write enable
- oRam_Addr  out  ADDR_W  RAM word index
- oRam_WrData  out  32  RAM write data
- iRam_RdData  in  32  RAM combinational read data for oRam_Addr

Behaviour:
- Reset (iRst_n low, asynchronous):
  - FSM goes to IDLE; round-robin pointer favours A.
  - All outputs are 0: Gnt, Done, Err, RdData, oBusy, oRam_WrEn, oRam_Addr, oRam_WrData.
- Reset asserted mid-operation aborts the access immediately. No RAM write occurs unless oRam_WrEn was already sampled at a prior edge. No Done is issued.
- FSM states: IDLE, ACCESS, MERGE, DONE.
- IDLE:
  - If any Req is high, pulse Gnt for the chosen port and latch We, Funct3, Addr and WrData, then go to ACCESS.
  - If both ports request, grant the port not granted last. After reset, A wins the first tie.
  - A single requester is always granted.
- ACCESS:
  - oRam_Addr is driven from the latched address.
  - Load: capture the extended data, then go to DONE.
    - 000 LB: sign-extended byte at Addr[1:0]
    - 001 LH: sign-extended halfword at Addr[1]
    - 010 LW: full word
    - 100 LBU / 101 LHU: zero-extended
  - Store SW (010): oRam_WrEn=1 with oRam_WrData=WrData, then go to DONE.
  - Store SB/SH (000/001): capture iRam_RdData into the merge register, then go to MERGE.
- MERGE:
  - oRam_WrEn=1, oRam_WrData = captured word with the selected byte or halfword replaced by WrData[7:0] or WrData[15:0].
  - Then go to DONE.
- DONE:
  - Pulse Done for the served port. Update RdData for loads only; stores leave RdData unchanged.
  - Then go to IDLE. The next Gnt can occur in the following cycle.
- Latency from Gnt cycle to Done cycle:
  - Load and SW: 2 cycles.
  - SB/SH: 3 cycles.
- Invalid funct3 (loads 011/110/111; stores anything other than 000/001/010):
  - No RAM write; ACCESS goes directly to DONE.
  - Done and Err pulse together; RdData is unchanged.
- oRam_WrEn is high for exactly one cycle per valid store and never for loads.
- oBusy is high in ACCESS, MERGE and DONE.
- A Req that drops before its Gnt is simply not served.

Optional Feature:
- Macro: DMEM_ALIGN_CHK_EN.
- Defined: misaligned accesses are rejected like invalid funct3 (no write, Done+Err, RdData unchanged).
  - Misaligned means halfword with Addr[0]=1, or word with Addr[1:0]≠0.
- Undefined:
  - Halfword accesses ignore Addr[0]; word accesses ignore Addr[1:0].
  - No alignment Err is raised; Err is used only for invalid funct3.

Test Plan:
- A: SW 0x12345678 to addr 0x08, then LW 0x08 → oRam_WrEn one cycle at index 2; LW RdData = 0x12345678, Done 2 cycles after Gnt.
- Word 0x12345678 at 0x08, A: SB 0xAB to 0x09 → RAM word = 0x1234AB78; LB 0x09 = 0xFFFFFFAB; LBU 0x09 = 0x000000AB; Done 3 cycles after Gnt for SB.
- Word 0x8000FFFF at 0x04 → LH 0x06 = 0xFFFF8000; LHU 0x06 = 0x00008000; SH 0x5555 at 0x04 → word 0x80005555.
- A and B both request continuously → grants alternate A, B, A, B; no lost or duplicate Done; each RdData is routed only to its own port.
- Load funct3 011 and store funct3 100 → Done+Err, no oRam_WrEn. With DMEM_ALIGN_CHK_EN: LW at 0x02 → Err, no RAM effect; without it: LW at 0x02 returns the word at 0x00.
- SB issued, iRst_n pulsed low during MERGE → outputs cleared asynchronously, RAM word unchanged, no Done; a B request after reset is served normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Arbitrated RV32I load/store sequencer for a word-only data RAM; sub-word stores use read-modify-write.
// Optional: define DMEM_ALIGN_CHK_EN to reject misaligned halfword/word accesses with Err.
module dmem_access_ctrl #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iA_Req,
  input  logic              iA_We,
  input  logic [2:0]        iA_Funct3,
  input  logic [31:0]       iA_Addr,
  input  logic [31:0]       iA_WrData,
  input  logic              iB_Req,
  input  logic              iB_We,
  input  logic [2:0]        iB_Funct3,
  input  logic [31:0]       iB_Addr,
  input  logic [31:0]       iB_WrData,
  output logic              oA_Gnt,
  output logic              oA_Done,
  output logic [31:0]       oA_RdData,
  output logic              oA_Err,
  output logic              oB_Gnt,
  output logic              oB_Done,
  output logic [31:0]       oB_RdData,
  output logic              oB_Err,
  output logic              oBusy,
  output logic              oRam_WrEn,
  output logic [ADDR_W-1:0] oRam_Addr,
  output logic [31:0]       oRam_WrData,
  input  logic [31:0]       iRam_RdData
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, DONE} state_t;

  state_t            state_q, state_d;
  logic              fav_b_q, fav_b_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       rda_q, rda_d;
  logic [31:0]       rdb_q, rdb_d;
  logic              err_q, err_d;

  logic        pick_b, gnt_a, gnt_b, done, wr_en, reject, misalign;
  logic [31:0] wr_data, load_val, merged, shifted, mask;
  logic [15:0] half_sel;
  logic [4:0]  sh;
  logic        unused_addr;

  assign unused_addr = ^{iA_Addr[31:ADDR_W+2], iB_Addr[31:ADDR_W+2]};

  // On a tie the pointer picks the port that was not served last.
  assign pick_b = iB_Req & (~iA_Req | fav_b_q);

`ifdef DMEM_ALIGN_CHK_EN
  assign misalign = ((f3_q[1:0] == 2'b01) & addr_q[0]) |
                    ((f3_q[1:0] == 2'b10) & (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign reject = misalign | (we_q ? (f3_q[2] | (f3_q[1:0] == 2'b11))
                                   : ((f3_q == 3'b011) | (f3_q[2:1] == 2'b11)));

  always_comb begin
    shifted  = iRam_RdData >> {addr_q[1:0], 3'b000};
    half_sel = addr_q[1] ? iRam_RdData[31:16] : iRam_RdData[15:0];
    unique case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_val = iRam_RdData;
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = '0;
    endcase
    // Sub-word stores replace one lane of the word captured in ACCESS.
    if (f3_q[0]) begin
      sh     = {addr_q[1], 4'b0000};
      mask   = 32'h0000_FFFF << sh;
      merged = (merge_q & ~mask) | ({16'h0, wdata_q[15:0]} << sh);
    end else begin
      sh     = {addr_q[1:0], 3'b000};
      mask   = 32'h0000_00FF << sh;
      merged = (merge_q & ~mask) | ({24'h0, wdata_q[7:0]} << sh);
    end
  end

  always_comb begin
    state_d = state_q;
    fav_b_d = fav_b_q;
    port_d  = port_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rda_d   = rda_q;
    rdb_d   = rdb_q;
    err_d   = err_q;
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    done    = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    unique case (state_q)
      IDLE: begin
        if (iRst_n && (iA_Req || iB_Req)) begin
          gnt_a   = ~pick_b;
          gnt_b   = pick_b;
          port_d  = pick_b;
          fav_b_d = ~pick_b;
          we_d    = pick_b ? iB_We : iA_We;
          f3_d    = pick_b ? iB_Funct3 : iA_Funct3;
          addr_d  = pick_b ? iB_Addr[ADDR_W+1:0] : iA_Addr[ADDR_W+1:0];
          wdata_d = pick_b ? iB_WrData : iA_WrData;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        err_d   = reject;
        state_d = DONE;
        if (!reject) begin
          if (!we_q) begin
            if (port_q) rdb_d = load_val;
            else        rda_d = load_val;
          end else if (f3_q == 3'b010) begin
            wr_en   = 1'b1;
            wr_data = wdata_q;
          end else begin
            merge_d = iRam_RdData;
            state_d = MERGE;
          end
        end
      end
      MERGE: begin
        wr_en   = 1'b1;
        wr_data = merged;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      fav_b_q <= 1'b0;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rda_q   <= '0;
      rdb_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fav_b_q <= fav_b_d;
      port_q  <= port_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rda_q   <= rda_d;
      rdb_q   <= rdb_d;
      err_q   <= err_d;
    end
  end

  assign oA_Gnt      = gnt_a;
  assign oB_Gnt      = gnt_b;
  assign oA_Done     = done & ~port_q;
  assign oB_Done     = done & port_q;
  assign oA_Err      = done & ~port_q & err_q;
  assign oB_Err      = done & port_q & err_q;
  assign oA_RdData   = rda_q;
  assign oB_RdData   = rdb_q;
  assign oBusy       = (state_q != IDLE);
  assign oRam_WrEn   = wr_en;
  assign oRam_Addr   = addr_q[ADDR_W+1:2];
  assign oRam_WrData = wr_data;

endmodule
